dmem_arbiter: RTL

Two-requester arbiter and access sequencer in front of the single-port data memory. Shares the memory port between the core load/store unit (port 0) and a DMA/program-loader requester (port 1) using round-robin arbitration and valid/ready handshakes. Checks alignment, funct3 legality and address range before any access, and returns registered read data or an error response to the winning requester.

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and one-cycle access sequencer for the
// single-port data memory. Requests are legality-checked when accepted; the
// winning port receives a registered response one cycle after its access.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [2:0]            req0_funct3,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [2:0]            req1_funct3,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp0_valid,
  output logic                  resp0_err,
  output logic [DATA_WIDTH-1:0] resp0_rdata,
  output logic                  resp1_valid,
  output logic                  resp1_err,
  output logic [DATA_WIDTH-1:0] resp1_rdata,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // One past the last legal byte address; one bit wider so MEM_SIZE*4 never wraps.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE) << 2;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;
  logic                    grant_vld;
  logic                    grant_port;

  logic                    sel_we;
  logic [2:0]              sel_funct3;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  logic                    we_p1;
  logic [2:0]              funct3_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [DATA_WIDTH-1:0]   wdata_p1;
  logic                    port_p1;
  logic                    err_p1;

  // A request is rejected for an unknown width code, a misaligned address,
  // or an address beyond the end of the memory.
  function automatic logic access_err(input logic                  we,
                                      input logic [2:0]            funct3,
                                      input logic [ADDR_WIDTH-1:0] addr);
    logic bad_code;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      bad_code = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      bad_code = funct3 inside {3'b011, 3'b110, 3'b111};
    end
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
    return bad_code || misaligned || out_of_range;
  endfunction

  // Arbitration and next state: only an IDLE cycle out of reset grants, and
  // under contention the port that did not win last time goes first.
  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_vld  = 1'b1;
          grant_port = ~last_grant;
        end else if (req0_valid) begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end else if (req1_valid) begin
          grant_vld  = 1'b1;
          grant_port = 1'b1;
        end
        if (!rst_n) begin
          grant_vld = 1'b0;
        end
        if (grant_vld) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    req0_ready = grant_vld && !grant_port;
    req1_ready = grant_vld && grant_port;
  end

  // Payload of whichever port is being granted this cycle.
  always_comb begin
    sel_we     = grant_port ? req1_we     : req0_we;
    sel_funct3 = grant_port ? req1_funct3 : req0_funct3;
    sel_addr   = grant_port ? req1_addr   : req0_addr;
    sel_wdata  = grant_port ? req1_wdata  : req0_wdata;
  end

  // Control state: sequencer state and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        last_grant <= grant_port;
      end
    end
  end

  // Accept stage: hold the granted request and its verdict for the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      we_p1     <= sel_we;
      funct3_p1 <= sel_funct3;
      addr_p1   <= sel_addr;
      wdata_p1  <= sel_wdata;
      port_p1   <= grant_port;
      err_p1    <= access_err(sel_we, sel_funct3, sel_addr);
    end
  end

  // Memory port: idle values except during an error-free ACCESS; writes are
  // gated by rst_n so a reset mid-access never commits a store.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_funct3  = 3'b010;
    mem_addr    = '0;
    mem_wr_data = '0;
    if ((state == ACCESS) && !err_p1) begin
      mem_wr_en   = we_p1 && rst_n;
      mem_funct3  = funct3_p1;
      mem_addr    = addr_p1;
      mem_wr_data = wdata_p1;
    end
  end

  // Response stage: one-cycle pulse to the serviced port; err/rdata persist
  // until that port's next response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp0_err   <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_err   <= 1'b0;
      resp1_rdata <= '0;
    end else begin
      resp0_valid <= (state == ACCESS) && !port_p1;
      resp1_valid <= (state == ACCESS) && port_p1;
      if (state == ACCESS) begin
        if (!port_p1) begin
          resp0_err   <= err_p1;
          resp0_rdata <= (err_p1 || we_p1) ? '0 : mem_rd_data;
        end else begin
          resp1_err   <= err_p1;
          resp1_rdata <= (err_p1 || we_p1) ? '0 : mem_rd_data;
        end
      end
    end
  end

endmodule
